// File: rtl/aurora_hls_nfc_pkg.sv
// Shared constants and state encoding for the Aurora NFC pause arbiter.
package aurora_hls_nfc_pkg;

  localparam logic [15:0] NFC_XOFF = 16'hFFFF;
  localparam logic [15:0] NFC_XON  = 16'h0000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_XOFF = 2'd1,
    PAUSED    = 2'd2,
    SEND_XON  = 2'd3
  } nfc_state_e;

  function automatic logic nfc_state_sends(input nfc_state_e s);
    return (s == SEND_XOFF) || (s == SEND_XON);
  endfunction

  function automatic logic [15:0] nfc_state_word(input nfc_state_e s);
    return (s == SEND_XOFF) ? NFC_XOFF : NFC_XON;
  endfunction

endpackage

// File: rtl/aurora_hls_nfc_refresh_timer.sv
// Down-counter that pulses expire after REFRESH_CYCLES enabled cycles; inert when REFRESH_CYCLES is 0.
module aurora_hls_nfc_refresh_timer #(
  parameter int REFRESH_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int TW = (REFRESH_CYCLES < 2) ? 1 : $clog2(REFRESH_CYCLES + 1);
  localparam logic [TW-1:0] LOAD_VAL = TW'(REFRESH_CYCLES);
  localparam logic [TW-1:0] ONE      = TW'(1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = LOAD_VAL;
    end else if (enable && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal count is 1 so the resend leaves PAUSED after exactly REFRESH_CYCLES cycles.
  assign expire = (REFRESH_CYCLES != 0) && enable && (cnt_q == ONE);

endmodule

// File: rtl/aurora_hls_nfc_arbiter.sv
// Merges NUM_REQ pause requests onto one Aurora NFC stream: XOFF on first request,
// XON once all release, periodic XOFF refresh while paused, saturating event counters.
//
// state     | meaning
// IDLE      | link not paused, no word pending
// SEND_XOFF | XOFF word presented, waiting for tready (initial or refresh)
// PAUSED    | partner paused, refresh timer running while want holds
// SEND_XON  | XON word presented, waiting for tready
module aurora_hls_nfc_arbiter
  import aurora_hls_nfc_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int REFRESH_CYCLES = 4096,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   channel_up,
  input  logic [NUM_REQ-1:0]     req_xoff,
  output logic                   s_axi_nfc_tvalid,
  input  logic                   s_axi_nfc_tready,
  output logic [15:0]            s_axi_nfc_tdata,
  output logic                   paused,
  output logic [NUM_REQ-1:0]     cause_mask,
  output logic [COUNT_WIDTH-1:0] xoff_count,
  output logic [COUNT_WIDTH-1:0] xon_count,
  output logic [COUNT_WIDTH-1:0] refresh_count
);

  nfc_state_e             state_q, state_d;
  logic                   refresh_q, refresh_d;
  logic                   paused_q, paused_d;
  logic [NUM_REQ-1:0]     cause_q, cause_d;
  logic [COUNT_WIDTH-1:0] xoff_cnt_q, xoff_cnt_d;
  logic [COUNT_WIDTH-1:0] xon_cnt_q, xon_cnt_d;
  logic [COUNT_WIDTH-1:0] ref_cnt_q, ref_cnt_d;

  logic want;
  logic tmr_load, tmr_en, tmr_clr, tmr_expire;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign want    = (|req_xoff) & channel_up;
  assign tmr_en  = (state_q == PAUSED) && want;
  assign tmr_clr = !channel_up;

  aurora_hls_nfc_refresh_timer #(
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_refresh_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (tmr_clr),
    .load  (tmr_load),
    .enable(tmr_en),
    .expire(tmr_expire)
  );

  always_comb begin
    state_d    = state_q;
    refresh_d  = refresh_q;
    paused_d   = paused_q;
    cause_d    = cause_q;
    xoff_cnt_d = xoff_cnt_q;
    xon_cnt_d  = xon_cnt_q;
    ref_cnt_d  = ref_cnt_q;
    tmr_load   = 1'b0;
    // Link down discards any pending word; the core drops it, so nothing is counted.
    if (!channel_up) begin
      state_d   = IDLE;
      refresh_d = 1'b0;
      paused_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (want) begin
            state_d   = SEND_XOFF;
            refresh_d = 1'b0;
            cause_d   = req_xoff;
          end
        end
        SEND_XOFF: begin
          if (s_axi_nfc_tready) begin
            state_d  = PAUSED;
            paused_d = 1'b1;
            tmr_load = 1'b1;
            if (refresh_q) ref_cnt_d  = sat_inc(ref_cnt_q);
            else           xoff_cnt_d = sat_inc(xoff_cnt_q);
          end
        end
        PAUSED: begin
          if (!want) begin
            state_d = SEND_XON;
          end else if (tmr_expire) begin
            state_d   = SEND_XOFF;
            refresh_d = 1'b1;
          end
        end
        SEND_XON: begin
          if (s_axi_nfc_tready) begin
            state_d   = IDLE;
            paused_d  = 1'b0;
            xon_cnt_d = sat_inc(xon_cnt_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      refresh_q  <= 1'b0;
      paused_q   <= 1'b0;
      cause_q    <= '0;
      xoff_cnt_q <= '0;
      xon_cnt_q  <= '0;
      ref_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      refresh_q  <= refresh_d;
      paused_q   <= paused_d;
      cause_q    <= cause_d;
      xoff_cnt_q <= xoff_cnt_d;
      xon_cnt_q  <= xon_cnt_d;
      ref_cnt_q  <= ref_cnt_d;
    end
  end

  assign s_axi_nfc_tvalid = nfc_state_sends(state_q);
  assign s_axi_nfc_tdata  = nfc_state_word(state_q);
  assign paused           = paused_q;
  assign cause_mask       = cause_q;
  assign xoff_count       = xoff_cnt_q;
  assign xon_count        = xon_cnt_q;
  assign refresh_count    = ref_cnt_q;

endmodule

// File: tb/tb_aurora_hls_nfc_arbiter.sv
// Directed bench for aurora_hls_nfc_arbiter with REFRESH_CYCLES=16.
module tb_aurora_hls_nfc_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        channel_up;
  logic [3:0]  req_xoff;
  logic        tvalid;
  logic        tready;
  logic [15:0] tdata;
  logic        paused;
  logic [3:0]  cause_mask;
  logic [31:0] xoff_count, xon_count, refresh_count;

  int total = 0;
  int bad   = 0;
  int n_xoff = 0, n_xon = 0, viol = 0;
  logic pv = 1'b0, pr = 1'b0, pc = 1'b0;
  logic [15:0] pd = 16'h0;

  always #5 clk = ~clk;

  aurora_hls_nfc_arbiter #(
    .NUM_REQ(4),
    .REFRESH_CYCLES(16),
    .COUNT_WIDTH(32)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .channel_up      (channel_up),
    .req_xoff        (req_xoff),
    .s_axi_nfc_tvalid(tvalid),
    .s_axi_nfc_tready(tready),
    .s_axi_nfc_tdata (tdata),
    .paused          (paused),
    .cause_mask      (cause_mask),
    .xoff_count      (xoff_count),
    .xon_count       (xon_count),
    .refresh_count   (refresh_count)
  );

  // Handshake counting and AXI-S hold-stable monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr && pc && (tvalid !== 1'b1 || tdata !== pd)) viol++;
      if (tvalid && tready) begin
        if (tdata == 16'hFFFF) n_xoff++;
        else n_xon++;
      end
      pv = tvalid;
      pr = tready;
      pc = channel_up;
      pd = tdata;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; channel_up = 1'b0; req_xoff = 4'b0; tready = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(10);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 16'h0000);
    chk("rst_paused", paused, 0);
    chk("rst_cause", cause_mask, 0);
    chk("rst_xoff_cnt", xoff_count, 0);
    chk("rst_xon_cnt", xon_count, 0);
    chk("rst_ref_cnt", refresh_count, 0);

    // XOFF held under backpressure, then accepted
    channel_up = 1'b1; req_xoff = 4'b0100;
    step(1);
    chk("t2_tvalid", tvalid, 1);
    chk("t2_tdata", tdata, 16'hFFFF);
    chk("t2_cause", cause_mask, 4'b0100);
    chk("t2_paused_pre", paused, 0);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("t2_hold_tvalid", tvalid, 1);
      chk("t2_hold_tdata", tdata, 16'hFFFF);
    end
    tready = 1'b1;
    step(1);
    chk("t2_hs_tvalid", tvalid, 0);
    chk("t2_hs_paused", paused, 1);
    chk("t2_hs_xoff_cnt", xoff_count, 1);
    chk("t2_hs_cause", cause_mask, 4'b0100);

    // requester hand-over while paused generates no traffic
    req_xoff = 4'b0101;
    step(2);
    chk("t3_tvalid_a", tvalid, 0);
    req_xoff = 4'b0001;
    step(2);
    chk("t3_tvalid_b", tvalid, 0);
    chk("t3_paused_b", paused, 1);
    chk("t3_words_xoff", n_xoff, 1);
    chk("t3_words_xon", n_xon, 0);
    req_xoff = 4'b0000;
    step(1);
    chk("t3_xon_tvalid", tvalid, 1);
    chk("t3_xon_tdata", tdata, 16'h0000);
    chk("t3_xon_paused", paused, 1);
    step(1);
    chk("t3_done_paused", paused, 0);
    chk("t3_done_tvalid", tvalid, 0);
    chk("t3_xon_cnt", xon_count, 1);
    chk("t3_cause_kept", cause_mask, 4'b0100);

    // refresh: XOFF accepted at E2, refreshes leave PAUSED at E18, E35, E52
    req_xoff = 4'b0010;
    step(1);
    chk("t4_tvalid", tvalid, 1);
    step(1);
    chk("t4_paused", paused, 1);
    chk("t4_xoff_cnt", xoff_count, 2);
    chk("t4_cause", cause_mask, 4'b0010);
    step(15);
    chk("t4_before_ref_tvalid", tvalid, 0);
    step(1);
    chk("t4_ref_tvalid", tvalid, 1);
    chk("t4_ref_tdata", tdata, 16'hFFFF);
    chk("t4_ref_paused", paused, 1);
    step(1);
    chk("t4_ref1_cnt", refresh_count, 1);
    chk("t4_ref1_xoff_cnt", xoff_count, 2);
    chk("t4_ref1_cause", cause_mask, 4'b0010);
    step(40);
    chk("t4_ref3_cnt", refresh_count, 3);
    chk("t4_ref3_xoff_cnt", xoff_count, 2);
    chk("t4_ref3_paused", paused, 1);
    req_xoff = 4'b0000;
    step(2);
    chk("t4_end_paused", paused, 0);
    chk("t4_end_xon_cnt", xon_count, 2);
    chk("t4_end_ref_cnt", refresh_count, 3);

    // request withdrawn while XOFF is backpressured: word still completes, then XON
    tready = 1'b0; req_xoff = 4'b1000;
    step(2);
    req_xoff = 4'b0000;
    step(1);
    chk("t5_hold_tvalid", tvalid, 1);
    chk("t5_hold_tdata", tdata, 16'hFFFF);
    tready = 1'b1;
    step(1);
    chk("t5_paused", paused, 1);
    chk("t5_xoff_cnt", xoff_count, 3);
    chk("t5_cause", cause_mask, 4'b1000);
    step(1);
    chk("t5_xon_tvalid", tvalid, 1);
    chk("t5_xon_tdata", tdata, 16'h0000);
    step(1);
    chk("t5_xon_cnt", xon_count, 3);
    chk("t5_end_paused", paused, 0);

    // link drop during pending XOFF
    tready = 1'b0; req_xoff = 4'b0001;
    step(1);
    chk("t6_tvalid", tvalid, 1);
    channel_up = 1'b0;
    step(1);
    chk("t6_down_tvalid", tvalid, 0);
    chk("t6_down_paused", paused, 0);
    chk("t6_down_xoff_cnt", xoff_count, 3);
    chk("t6_down_xon_cnt", xon_count, 3);
    chk("t6_down_ref_cnt", refresh_count, 3);
    chk("t6_down_cause", cause_mask, 4'b0001);
    channel_up = 1'b1;
    step(1);
    chk("t6_up_tvalid", tvalid, 1);
    chk("t6_up_tdata", tdata, 16'hFFFF);
    tready = 1'b1;
    step(1);
    chk("t6_up_xoff_cnt", xoff_count, 4);
    chk("t6_up_paused", paused, 1);
    req_xoff = 4'b0000;
    step(3);
    chk("t6_end_xon_cnt", xon_count, 4);
    chk("t6_end_paused", paused, 0);
    chk("words_xoff", n_xoff, 7);
    chk("words_xon", n_xon, 4);
    chk("axis_hold", viol, 0);

    // asynchronous reset mid-transfer
    tready = 1'b0; req_xoff = 4'b0100;
    step(1);
    chk("t7_tvalid", tvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rst_tvalid", tvalid, 0);
    chk("t7_rst_tdata", tdata, 16'h0000);
    chk("t7_rst_xoff_cnt", xoff_count, 0);
    chk("t7_rst_ref_cnt", refresh_count, 0);
    chk("t7_rst_cause", cause_mask, 0);
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("t7_post_tvalid", tvalid, 1);
    chk("t7_post_paused", paused, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
